// File: rtl/gdm_bram_reader.sv
// Burst reader: streams `length` words from a synchronous BRAM starting at base_addr
// through a 2-entry skid FIFO. Optional abort input is enabled by GDM_RD_ABORT_EN.
module gdm_bram_reader #(
    parameter int unsigned DATA_W = 75,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef GDM_RD_ABORT_EN
    ,
    input  logic              abort
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              done_q, done_d;
    logic              inflight_q, inflight_last_q;
    logic [DATA_W-1:0] mem_data_q [2];
    logic              mem_last_q [2];
    logic              wr_q, rd_q;
    logic [1:0]        count_q;
    logic [2:0]        occ;
    logic              pop, issue, flush;

`ifdef GDM_RD_ABORT_EN
    assign flush = abort && (state_q != StIdle);
`else
    assign flush = 1'b0;
`endif

    assign m_valid = (count_q != 2'd0);
    assign m_data  = mem_data_q[rd_q];
    assign m_last  = m_valid && mem_last_q[rd_q];
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign pop     = m_valid && m_ready;

    // Credit check: occupancy after this cycle's pop must leave room for a new read.
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue = (state_q == StRun) && (rem_q != '0) && !flush
                   && (occ < (3'd2 + {2'b00, pop}));

    // The BRAM sees the new address in the issuing cycle; otherwise the last one is held.
    assign bram_addr = issue ? ptr_q : addr_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d = base_addr;
                    rem_d = length;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (issue) begin
                    ptr_d  = ptr_q + ADDR_W'(1);
                    addr_d = ptr_q;
                    rem_d  = rem_q - (ADDR_W + 1)'(1);
                    if (rem_q == (ADDR_W + 1)'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && m_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            mem_data_q[0]   <= '0;
            mem_data_q[1]   <= '0;
            mem_last_q[0]   <= 1'b0;
            mem_last_q[1]   <= 1'b0;
            wr_q            <= 1'b0;
            rd_q            <= 1'b0;
            count_q         <= 2'd0;
        end else if (flush) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_q            <= 1'b0;
            rd_q            <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_q == (ADDR_W + 1)'(1));
            if (inflight_q) begin
                mem_data_q[wr_q] <= bram_dout;
                mem_last_q[wr_q] <= inflight_last_q;
                wr_q             <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

endmodule
